// File: rtl/regincr_pkg.sv
// rtl/regincr_pkg.sv - shared constants for the regincr output buffer blocks
package regincr_pkg;

  localparam int unsigned c_nbits     = 8;
  localparam int unsigned c_drop_bits = 8;
  localparam logic [c_drop_bits-1:0] c_drop_sat = '1;

endpackage

// File: rtl/regincr_fifo_ctrl.sv
// rtl/regincr_fifo_ctrl.sv - pointers, occupancy, handshake decode and drop counter
module regincr_fifo_ctrl
  import regincr_pkg::*;
#(
  parameter  int p_num_entries = 4,
  localparam int c_pw          = $clog2(p_num_entries),
  localparam int c_cw          = c_pw + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic                   deq_rdy,
  output logic                   enq_go,
  output logic                   deq_val,
  output logic [c_pw-1:0]        wptr,
  output logic [c_pw-1:0]        rptr,
  output logic [c_cw-1:0]        count,
  output logic [c_drop_bits-1:0] drop_count
);

  localparam logic [c_cw-1:0] c_full = c_cw'(p_num_entries);

  logic full;
  logic empty;
  logic deq_go;

  assign full    = (count == c_full);
  assign empty   = (count == '0);
  assign deq_val = !empty;
  assign deq_go  = deq_val && deq_rdy;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign enq_go  = enq_val && (!full || deq_go);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (enq_go) wptr <= wptr + 1'b1;
      if (deq_go) rptr <= rptr + 1'b1;
      if (enq_go && !deq_go)
        count <= count + 1'b1;
      else if (!enq_go && deq_go)
        count <= count - 1'b1;
      if (enq_val && !enq_go && (drop_count != c_drop_sat))
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: rtl/regincr_out_fifo.sv
// rtl/regincr_out_fifo.sv - registered output buffer behind the +2 incrementer
module regincr_out_fifo
  import regincr_pkg::*;
#(
  parameter  int p_nbits       = c_nbits,
  parameter  int p_num_entries = 4,
  localparam int c_pw          = $clog2(p_num_entries),
  localparam int c_cw          = c_pw + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  input  logic [p_nbits-1:0]     enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_nbits-1:0]     deq_msg,
  output logic [c_cw-1:0]        count,
  output logic [c_drop_bits-1:0] drop_count
);

  logic              enq_go;
  logic [c_pw-1:0]   wptr;
  logic [c_pw-1:0]   rptr;
  logic [p_nbits-1:0] mem [p_num_entries];

  regincr_fifo_ctrl #(
    .p_num_entries (p_num_entries)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .enq_val    (enq_val),
    .deq_rdy    (deq_rdy),
    .enq_go     (enq_go),
    .deq_val    (deq_val),
    .wptr       (wptr),
    .rptr       (rptr),
    .count      (count),
    .drop_count (drop_count)
  );

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (enq_go) mem[wptr] <= enq_msg;
  end

  assign deq_msg = mem[rptr];

endmodule
